// File: rtl/multiplier_seq.sv
// Sequential 32x32 signed multiplier using radix-2 Booth recoding.
// One Booth step per clock. The low 32 product bits and an overflow flag are
// registered on the final step. DONE lasts one cycle, then the FSM returns to IDLE.
module multiplier_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        mult_ready,
  output logic        mult_running
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [5:0]  count_reg;
  logic [31:0] m_reg;
  logic [31:0] q_reg;
  logic [32:0] acc_reg;
  logic        q_m1_reg;
  logic [31:0] result_reg;
  logic        exception_reg;

  logic [32:0] m_ext;
  logic [32:0] sum;
  logic [32:0] acc_next;
  logic [31:0] q_next;
  logic        q_m1_next;
  logic [32:0] prod_hi;
  logic [31:0] sign_diff;
  logic        overflow;

  // One Booth step: add, subtract or keep M, then arithmetic-shift {acc, Q, q_-1} right by one.
  // The 33-bit accumulator lets -M be represented even when M = 0x80000000.
  always_comb begin
    m_ext = {m_reg[31], m_reg};
    sum   = acc_reg;
    case ({q_reg[0], q_m1_reg})
      2'b01:   sum = acc_reg + m_ext;
      2'b10:   sum = acc_reg - m_ext;
      default: sum = acc_reg;
    endcase
    acc_next  = {sum[32], sum[32:1]};
    q_next    = {sum[0], q_reg[31:1]};
    q_m1_next = q_reg[0];
  end

  // After the last step, product[63:31] must consist of 33 copies of one bit for the product to fit in 32 bits.
  assign prod_hi = {acc_next[31:0], q_next[31]};

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sign_diff
      assign sign_diff[gi] = prod_hi[gi] ^ prod_hi[gi + 1];
    end
  endgenerate

  assign overflow = |sign_diff;

  // FSM and datapath. Reset has the highest priority. A start request in any state then restarts the operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= 6'd0;
      m_reg         <= 32'd0;
      q_reg         <= 32'd0;
      acc_reg       <= 33'd0;
      q_m1_reg      <= 1'b0;
      result_reg    <= 32'd0;
      exception_reg <= 1'b0;
    end else if (ctrl_MULT) begin
      state_reg <= RUN;
      count_reg <= 6'd0;
      m_reg     <= data_operandA;
      q_reg     <= data_operandB;
      acc_reg   <= 33'd0;
      q_m1_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          acc_reg   <= acc_next;
          q_reg     <= q_next;
          q_m1_reg  <= q_m1_next;
          count_reg <= count_reg + 6'd1;
          if (count_reg == 6'd31) begin
            state_reg     <= DONE;
            result_reg    <= q_next;
            exception_reg <= overflow;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exception_reg;
  assign mult_ready     = (state_reg == DONE);
  assign mult_running   = (state_reg == RUN);

endmodule

// File: tb/tb_multiplier_seq.sv
// Scoreboard bench for multiplier_seq.
// The stimulus process pushes the expected result, exception flag and completion cycle.
// The monitor pops and compares on every mult_ready pulse.
module tb_multiplier_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        mult_ready;
  logic        mult_running;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   checks = 0;
  int   fails = 0;

  multiplier_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .mult_ready     (mult_ready),
    .mult_running   (mult_running)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle_cnt);
    end
  endtask

  // Monitor: compare each completion against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mult_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(data_result == e.res, "result", data_result, e.res);
          chk(data_exception == e.exc, "exception", {31'd0, data_exception}, {31'd0, e.exc});
          chk(cycle_cnt == e.cyc, "latency_cycle", cycle_cnt, e.cyc);
          chk(!mult_running, "ready_running_excl", {31'd0, mult_running}, 32'd0);
          $display("txn: result=0x%08h exc=%0b cycle=%0d", data_result, data_exception, cycle_cnt);
        end
      end
    end
  end

  // Load one operation. The load edge is the posedge inside this task.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e, input bit push);
    exp_t x;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    if (push) begin
      x.res = r; x.exc = e; x.cyc = cycle_cnt + 32;
      sb.push_back(x);
    end
  endtask

  // Wait until the scoreboard is empty, with a bounded number of cycles.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk(1'b0, "drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t vecs[8];
  exp_t x;

  initial begin
    vecs[0] = '{32'd3,         32'd5,         32'h0000000F, 1'b0};
    vecs[1] = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFD6, 1'b0};
    vecs[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 1'b0};
    vecs[3] = '{32'h7FFFFFFF,  32'd2,         32'hFFFFFFFE, 1'b1};
    vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1'b1};
    vecs[5] = '{32'h00010000,  32'h00010000,  32'h00000000, 1'b1};
    vecs[6] = '{32'h80000000,  32'h80000000,  32'h00000000, 1'b1};
    vecs[7] = '{32'h00000000,  32'h12345678,  32'h00000000, 1'b0};

    // Reset takes priority over a start request on the same edge.
    reset = 1'b1; ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk(data_result == 32'd0, "rst_result", data_result, 32'd0);
    chk(data_exception == 1'b0, "rst_exc", {31'd0, data_exception}, 32'd0);
    chk(mult_ready == 1'b0, "rst_ready", {31'd0, mult_ready}, 32'd0);
    chk(mult_running == 1'b0, "rst_running", {31'd0, mult_running}, 32'd0);
    reset = 1'b0; ctrl_MULT = 1'b0;
    @(negedge clock);
    chk(mult_running == 1'b0, "idle_running", {31'd0, mult_running}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e, 1'b1);
      drain();
    end

    // Operands change every RUN cycle. The result must still be 3*5 and must hold afterwards.
    issue(32'd3, 32'd5, 32'h0F, 1'b0, 1'b1);
    for (int i = 0; i < 31; i++) begin
      @(negedge clock);
      data_operandA = $urandom;
      data_operandB = $urandom;
      if (i == 5) begin
        chk(mult_running == 1'b1, "run_running", {31'd0, mult_running}, 32'd1);
        chk(mult_ready == 1'b0, "run_ready", {31'd0, mult_ready}, 32'd0);
      end
    end
    drain();
    repeat (5) @(negedge clock);
    chk(data_result == 32'h0F, "hold_result", data_result, 32'h0F);
    chk(mult_running == 1'b0, "hold_running", {31'd0, mult_running}, 32'd0);

    // A start request during DONE still gives this cycle's ready pulse, and the new operation is loaded on that edge.
    issue(32'd6, 32'd7, 32'd42, 1'b0, 1'b1);
    repeat (32) @(posedge clock);
    @(negedge clock);
    chk(mult_ready == 1'b1, "done_state_ready", {31'd0, mult_ready}, 32'd1);
    data_operandA = 32'd9; data_operandB = 32'hFFFFFFFE; ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    x.res = 32'hFFFFFFEE; x.exc = 1'b0; x.cyc = cycle_cnt + 32;
    sb.push_back(x);
    drain();

    // A start request held high: counting begins from the last high edge, using that edge's operands.
    @(negedge clock);
    data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
    @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd2; data_operandB = 32'd7;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    x.res = 32'd14; x.exc = 1'b0; x.cyc = cycle_cnt + 32;
    sb.push_back(x);
    drain();

    // Abort: restart 3*5 at step 10 with 4*4. Only the second operation may complete.
    issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clock);
    issue(32'd4, 32'd4, 32'h10, 1'b0, 1'b1);
    drain();
    repeat (40) @(posedge clock);

    // Reset during RUN: no ready pulse, and all outputs return to zero.
    issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk(data_result == 32'd0, "rst_run_result", data_result, 32'd0);
    chk(data_exception == 1'b0, "rst_run_exc", {31'd0, data_exception}, 32'd0);
    chk(mult_running == 1'b0, "rst_run_running", {31'd0, mult_running}, 32'd0);
    chk(mult_ready == 1'b0, "rst_run_ready", {31'd0, mult_ready}, 32'd0);
    repeat (40) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 No parameters; operand width SHALL be fixed at 32 bits.
REQ-002 clock  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 data_operandA  input  32  Signed multiplicand, two's complement.
REQ-005 data_operandB  input  32  Signed multiplier, two's complement.
REQ-006 ctrl_MULT  input  1  Start strobe; sampled on each rising edge.
REQ-007 data_result  output  32  Low 32 bits of the signed product; registered.
REQ-008 data_exception  output  1  Overflow flag; registered.
REQ-009 mult_ready  output  1  One-cycle done pulse.
REQ-010 mult_running  output  1  High while iterations are in progress.

Function
REQ-011 The block SHALL have three states: IDLE, RUN and DONE, with a 6-bit iteration counter.
REQ-012 ctrl_MULT sampled high in any state, with reset low, SHALL capture A as M and B as Q, clear the 33-bit upper accumulator and q_-1, zero the counter, and enter RUN.
REQ-013 Operands SHALL be sampled only on the load edge; later changes on data_operandA and data_operandB SHALL have no effect on the running operation.
REQ-014 Each RUN edge SHALL perform one radix-2 Booth step on {Q[0], q_-1}:
- 01: add M (sign-extended to 33 bits) to the accumulator.
- 10: subtract M.
- 00 or 11: no add.
- Then arithmetic-shift {acc, Q, q_-1} right by 1 and increment the counter.
REQ-015 Arithmetic SHALL use a 33-bit accumulator so that M = 0x80000000 is subtracted without loss.
REQ-016 After the 32nd step, which is 32 edges after the load edge, the state SHALL move to DONE.
REQ-017 On the same edge, data_result SHALL load product[31:0].
REQ-018 On the same edge, data_exception SHALL load 1 if product[63:31] is not all-equal (the product does not fit in 32 signed bits), else 0.
REQ-019 mult_ready SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL then go to IDLE.
REQ-020 mult_running SHALL be 1 exactly in RUN; mult_ready and mult_running SHALL never both be 1.
REQ-021 data_result and data_exception SHALL hold their values through IDLE and RUN until the next DONE.
REQ-022 ctrl_MULT high during RUN SHALL abort the current operation and restart with the new operands; no mult_ready SHALL be produced for the aborted operation.
REQ-023 ctrl_MULT high during DONE SHALL still pulse mult_ready that cycle and SHALL start the new operation in RUN on the next cycle.
REQ-024 ctrl_MULT held high for several cycles SHALL restart the operation on every such edge; the 32-step count begins from the last high edge.
REQ-025 Latency SHALL be fixed at 32 cycles from the load edge to the mult_ready assertion, independent of operand values.

Reset
REQ-026 reset high on an edge SHALL force IDLE, counter to 0, all datapath registers to 0, data_result to 0, data_exception to 0, mult_ready to 0 and mult_running to 0.
REQ-027 reset SHALL take priority over ctrl_MULT on the same edge.
REQ-028 reset during RUN SHALL abort the operation with no mult_ready pulse.

Verification
REQ-029 Load A=3, B=5 -> mult_ready exactly 32 cycles after the load edge; data_result=0x0000000F, data_exception=0.
REQ-030 A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6 (-42), exception=0; A=-1, B=-1 -> result=0x00000001, exception=0.
REQ-031 A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1; A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1; A=0x00010000, B=0x00010000 -> result=0, exception=1.
REQ-032 Start 3*5, assert ctrl_MULT at step 10 with A=4, B=4 -> a single mult_ready 32 cycles after the second load edge, result=0x10.
REQ-033 Start 3*5, assert reset at step 20 -> no mult_ready; all outputs 0; mult_running=0 from the next cycle.
REQ-034 Change data_operandA and data_operandB on every RUN cycle of 3*5 -> result still 0x0F; the result holds after mult_ready until the next DONE.
